// File: rtl/conv_mac_sequencer.sv
// Convolution window sequencer: streams TAPS operand pairs through an external pipelined
// multiplier and accumulates the products. Define CONV_MAC_SAT_EN to saturate instead of wrap.
module conv_mac_sequencer #(
  parameter int DATA_W      = 8,
  parameter int PROD_W      = 16,
  parameter int ACC_W       = 24,
  parameter int TAPS        = 9,
  parameter int MUL_LATENCY = 1
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] mul_dataa,
  output logic [DATA_W-1:0] mul_datab,
  input  logic [PROD_W-1:0] mul_result,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_ovf,
  output logic              done
);
  localparam int CNT_W = $clog2(TAPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUTPUT} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_issue_cnt, r_recv_cnt;
  logic [MUL_LATENCY:0] r_vld_pipe;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf, r_done;
  logic [DATA_W-1:0]   r_mul_a, r_mul_b;

  logic             w_hs, w_acc_en, w_last_issue, w_last_recv, w_accept, w_begin;
  logic [ACC_W:0]   w_sum;

  assign w_hs         = in_valid && (r_state == S_ISSUE);
  assign w_acc_en     = r_vld_pipe[MUL_LATENCY];
  assign w_last_issue = w_hs && (r_issue_cnt == CNT_W'(TAPS - 1));
  assign w_last_recv  = w_acc_en && (r_recv_cnt == CNT_W'(TAPS - 1));
  assign w_accept     = (r_state == S_OUTPUT) && acc_ready;
  assign w_begin      = (r_state == S_IDLE) && start;
  // One extra bit so the carry out of the accumulator is visible.
  assign w_sum        = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, mul_result};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start)        w_state_nxt = S_ISSUE;
      S_ISSUE:  if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_last_recv)  w_state_nxt = S_OUTPUT;
      S_OUTPUT: if (acc_ready)    w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_vld_pipe  <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_accept;
      // Slot i of the pipe tracks the operand pair registered i edges ago.
      r_vld_pipe <= {r_vld_pipe[MUL_LATENCY-1:0], w_hs};
      r_mul_a    <= w_hs ? in_a : '0;
      r_mul_b    <= w_hs ? in_b : '0;

      if (w_begin)   r_issue_cnt <= '0;
      else if (w_hs) r_issue_cnt <= r_issue_cnt + 1'b1;

      if (w_begin) begin
        r_recv_cnt <= '0;
        r_acc      <= '0;
        r_ovf      <= 1'b0;
      end else if (w_acc_en) begin
        r_recv_cnt <= r_recv_cnt + 1'b1;
        r_ovf      <= r_ovf | w_sum[ACC_W];
`ifdef CONV_MAC_SAT_EN
        if (w_sum[ACC_W] || r_ovf) r_acc <= '1;
        else                       r_acc <= w_sum[ACC_W-1:0];
`else
        r_acc <= w_sum[ACC_W-1:0];
`endif
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = (r_state == S_ISSUE);
  assign acc_valid = (r_state == S_OUTPUT);
  assign acc_data  = r_acc;
  assign acc_ovf   = r_ovf;
  assign done      = r_done;
  assign mul_dataa = r_mul_a;
  assign mul_datab = r_mul_b;
endmodule
